// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the IF/ID and ID/EX buffers.
// Handles load-use bubbles, taken-branch front-end flushes and multi-cycle EX
// occupancy (mul/div).
// Optional feature macro: HAZ_PERF_CNT_EN builds the stall_cnt performance
// counter and its perf_clr clear. Without it, stall_cnt is tied to zero.
module hazard_ctrl #(
    parameter int MC_CYCLES = 4,   // EX occupancy of a multi-cycle op, 2..16
    parameter int REG_W     = 4    // register index width
) (
    input  logic             C,
    input  logic             R,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_mc,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             branch_taken,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             ex_busy,
    output logic             ex_done,
    output logic [15:0]      stall_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MC_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hazard;

    // A load in EX writing a register that the ID instruction actually reads.
    assign hazard = ex_memread && (ex_rd != '0) &&
                    ((id_use1 && (ex_rd == id_rs1)) || (id_use2 && (ex_rd == id_rs2)));

    // State and multi-cycle countdown registers.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and decode outputs; everything is held at 0 while reset is asserted.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case/if tree can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        ex_busy    = 1'b0;
        ex_done    = 1'b0;
        if (R) begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        // Squash both wrong-path instructions; branch target loads into PC.
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                    end else if (hazard) begin
                        // Hold PC and IF/ID for one cycle, insert a bubble into EX.
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        idex_en = 1'b1;
                        if (id_mc) begin
                            state_d = BUSY;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    ex_busy = 1'b1;
                    if (cnt_q == 4'd0) begin
                        ex_done = 1'b1;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating stalled-cycle count; a clear request takes priority.
    always_comb begin
        stall_d = stall_q;
        if (perf_clr) begin
            stall_d = '0;
        end else if (!pc_en && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr;
    assign stall_cnt       = 16'h0000;
`endif

endmodule
